// File: rtl/memory_pair_fetch.sv
// Sweeps the state vector for one single-qubit operation, fetching each
// amplitude pair (idx_a, idx_b = idx_a | 2^target) and handing it downstream.
module memory_pair_fetch #(
  parameter int DATA_W = 32,
  parameter int N_MAX  = 10,
  localparam int ADDR_W = N_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        n_qubits,
  input  logic [3:0]        target,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data_r,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A_r,
  output logic [DATA_W-1:0] A_i,
  output logic [DATA_W-1:0] B_r,
  output logic [DATA_W-1:0] B_i,
  output logic [ADDR_W-1:0] idx_a,
  output logic [ADDR_W-1:0] idx_b
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP,
    OUT,
    DONE
  } state_t;

  state_t state, state_d;

  logic [3:0]        nq_q;
  logic [3:0]        tgt_q;
  logic [ADDR_W-1:0] p;
  logic [ADDR_W-1:0] bit_t;
  logic [ADDR_W-1:0] low_mask;
  logic [ADDR_W-1:0] pair_a;
  logic [ADDR_W-1:0] pair_b;
  logic [ADDR_W-1:0] last_p;
  logic              cfg_ok;
  logic              is_last;

  // Insert a zero at bit position target: low bits stay, high bits shift up one.
  assign bit_t    = ADDR_W'(1) << tgt_q;
  assign low_mask = bit_t - ADDR_W'(1);
  assign pair_a   = ((p & ~low_mask) << 1) | (p & low_mask);
  assign pair_b   = pair_a | bit_t;
  assign last_p   = (ADDR_W'(1) << (nq_q - 4'd1)) - ADDR_W'(1);
  assign is_last  = (p == last_p);

  assign cfg_ok = (n_qubits != 4'd0) && (int'(n_qubits) <= N_MAX) && (target < n_qubits);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == OUT);

  always_comb begin
    state_d     = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state)
      IDLE: if (start && cfg_ok) state_d = RD_A;
      RD_A: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = pair_a;
        state_d     = RD_B;
      end
      RD_B: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = pair_b;
        state_d     = CAP;
      end
      CAP:  state_d = OUT;
      OUT:  if (out_ready) state_d = is_last ? DONE : RD_A;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Read data lags the strobe by one cycle: A arrives in RD_B, B arrives in CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err   <= 1'b0;
      nq_q  <= '0;
      tgt_q <= '0;
      p     <= '0;
      A_r   <= '0;
      A_i   <= '0;
      B_r   <= '0;
      B_i   <= '0;
      idx_a <= '0;
      idx_b <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            nq_q  <= n_qubits;
            tgt_q <= target;
            p     <= '0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        RD_B: begin
          A_r <= mem_rd_data_r;
          A_i <= mem_rd_data_i;
        end
        CAP: begin
          B_r   <= mem_rd_data_r;
          B_i   <= mem_rd_data_i;
          idx_a <= pair_a;
          idx_b <= pair_b;
        end
        OUT: if (out_ready && !is_last) p <= p + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/memory_pair_fetch.md
MEMORY_PAIR_FETCH -- requirements
Module: memory_pair_fetch

Interface
REQ-001 Parameter DATA_W, default 32, width of each real or imaginary amplitude component (signed two's complement).
REQ-002 Parameter N_MAX, default 10, maximum qubit count; ADDR_W = N_MAX.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to sweep the state vector for one single-qubit operation.
REQ-006 n_qubits  input  4  qubit count; valid range 1..N_MAX.
REQ-007 target  input  4  target qubit; valid range 0..n_qubits-1.
REQ-008 busy  output  1  high from the accepted start until the end of the done cycle.
REQ-009 done  output  1  one-cycle pulse after the last pair is handed off.
REQ-010 err  output  1  one-cycle pulse when start is rejected for invalid n_qubits or target.
REQ-011 mem_rd_en  output  1  state-memory read strobe.
REQ-012 mem_rd_addr  output  ADDR_W  state-memory read address.
REQ-013 mem_rd_data_r, mem_rd_data_i  input  DATA_W each  read data; valid exactly one cycle after mem_rd_en.
REQ-014 out_valid  output  1  operand pair available.
REQ-015 out_ready  input  1  downstream complex arithmetic stage accepts the pair.
REQ-016 A_r, A_i, B_r, B_i  output  DATA_W each  amplitude at idx_a (A) and amplitude at idx_b (B).
REQ-017 idx_a, idx_b  output  ADDR_W each  state indices of the presented pair, used for write-back.

Function
REQ-018 Pair counter p SHALL run 0..2^(n_qubits-1)-1.
- idx_a = p with a 0 inserted at bit position target: ((p>>target)<<(target+1)) | (p & (2^target-1)).
- idx_b = idx_a | 2^target.
REQ-019 FSM states SHALL be IDLE, RD_A, RD_B, CAP, OUT, DONE.
REQ-020 In IDLE, a start with a valid configuration SHALL:
- latch n_qubits and target;
- clear p;
- go to RD_A.
REQ-021 In IDLE, a start with n_qubits=0, n_qubits>N_MAX, or target>=n_qubits SHALL pulse err for one cycle and remain in IDLE with busy=0.
REQ-022 RD_A SHALL drive mem_rd_en=1 and mem_rd_addr=idx_a, then go to RD_B.
REQ-023 RD_B SHALL:
- drive mem_rd_en=1 and mem_rd_addr=idx_b;
- capture mem_rd_data_r/i into A_r/A_i;
- go to CAP.
REQ-024 CAP SHALL:
- capture the returned data into B_r/B_i;
- register idx_a and idx_b;
- go to OUT.
REQ-025 OUT SHALL hold out_valid=1. On out_ready=1 it SHALL go to DONE if p is the last pair; otherwise it SHALL increment p and go to RD_A.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-027 mem_rd_en SHALL be 0 in IDLE, CAP, OUT and DONE.
REQ-028 Timing:
- start sampled at edge E0 gives RD_A after E0 and out_valid=1 from E3;
- minimum 4 cycles per pair;
- done rises one edge after the final handshake.
REQ-029 While out_valid=1 and out_ready=0, A_*, B_*, idx_a and idx_b SHALL remain stable.
REQ-030 start SHALL be ignored while busy=1; latched n_qubits and target SHALL not change mid-sweep.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 Amplitude data SHALL pass through bit-exact, with no arithmetic, rounding or sign change.

Reset
REQ-033 On rst=1, with immediate effect independent of clk:
- state SHALL be IDLE and p SHALL be 0;
- busy, done, err, mem_rd_en and out_valid SHALL be 0;
- mem_rd_addr, idx_a, idx_b, A_*, B_* SHALL be 0.
REQ-034 Reset asserted mid-sweep SHALL abort the sweep with no done pulse. The first start after reset release SHALL begin a fresh sweep from p=0.

Verification
REQ-035 Start with n_qubits=3, target=0, memory[i]=(i,-i), out_ready=1. Required:
- pairs (0,1),(2,3),(4,5),(6,7) in order, with A_r=idx_a and B_i=-idx_b;
- exactly 4 handshakes, then one done pulse.
REQ-036 Start with n_qubits=3, target=2. Required: pairs (0,4),(1,5),(2,6),(3,7), and mem_rd_addr sequence 0,4,1,5,2,6,3,7.
REQ-037 Start with n_qubits=1, target=0. Required: single pair (0,1) with out_valid at E3, done one edge after the handshake, busy=0 the following cycle.
REQ-038 Backpressure: out_ready=0 for 5 cycles on the second pair. Required: outputs stable for those 5 cycles, no memory reads, sequence otherwise unchanged.
REQ-039 Invalid start:
- n_qubits=3, target=3 gives a 1-cycle err pulse, busy stays 0, no mem_rd_en;
- n_qubits=0 gives the same response.
REQ-040 Reset and restart: assert rst during RD_B of the third pair (n_qubits=4, target=1). Required:
- all outputs 0 at once, no done pulse;
- a restart yields pair (0,2) first.
